burst_sched: RTL
================

# burst_sched

Round-robin scheduler that shares one FIFO-to-AXI-Stream packer and its downstream HLS accelerator between several burst producers. It grants one requester at a time and issues the packer's `start` pulse. It then streams exactly `BURST` words from the granted requester into the packer's write port. It holds the grant until the accelerator signals completion with `acc_tlast`, or until a timeout expires.

## Interface
- `NREQ`, 4: number of requesters; must be at least 2.
- `DATA_WIDTH`, 32: word width.
- `BURST`, 4: words per burst; must equal the packer threshold and be at least 1.
- `TIMEOUT`, 1023: maximum cycles spent in WAIT_DONE; must be at least 1.

- `clk` input 1: single clock; all logic is rising-edge.
- `rst_n` input 1: reset; asynchronous assert, active-low.
- `req` input NREQ: requester i holds a word available at `req_data` slice i.
- `req_data` input NREQ*DATA_WIDTH: flattened data; slice i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ack` output NREQ: pop strobe for requester i; one word is consumed per high cycle.
- `grant` output NREQ: one-hot grant for the current owner; zero when idle.
- `done` output NREQ: 1-cycle pulse on the owner's bit when its burst completes.
- `pk_start` output 1: packer start pulse.
- `pk_write` output 1: packer write strobe.
- `pk_din` output DATA_WIDTH: packer write data.
- `acc_tlast` input 1: accelerator end-of-result indication.
- `busy` output 1: high whenever state is not IDLE.
- `err` output 1: sticky timeout flag.
- `err_clr` input 1: synchronous clear for `err`.

## Operation
- States: IDLE, START, LOAD, WAIT_DONE.
- IDLE
  - If `req` is nonzero, register a one-hot `grant` for the first set bit found by scanning from `ptr+1` modulo NREQ upward. Then go to START.
  - Otherwise stay in IDLE.
- START
  - `pk_start`=1 (registered, Moore output).
  - Clear `wcnt`, then go to LOAD unconditionally.
- LOAD
  - When `req[g]`=1 (g is the granted index): `pk_write`=1, `pk_din`=slice g, `req_ack[g]`=1, and `wcnt` increments. These three outputs are combinational from state, grant and `req`.
  - When `req[g]`=0: stall with `pk_write`=0 and `req_ack`=0; `pk_din` is don't-care.
  - On the write that makes `wcnt`=BURST, go to WAIT_DONE and clear `tmr`.
- WAIT_DONE
  - If `acc_tlast`=1: `done[g]` pulses (registered, visible the cycle after the tlast sample), `ptr`<=g, `grant`<=0, then go to IDLE.
  - Else if `tmr`=TIMEOUT-1: set `err`=1, leave `done` low, `ptr`<=g, `grant`<=0, then go to IDLE.
  - Otherwise `tmr` increments.
- `acc_tlast` is ignored outside WAIT_DONE.
- `req` bits of non-granted requesters are ignored while `busy` is high; `req_ack` stays zero on them.
- Widths:
  - `wcnt` is clog2(BURST+1) bits.
  - `tmr` is clog2(TIMEOUT+1) bits.
  - `ptr` is clog2(NREQ) bits and wraps from NREQ-1 to 0.
- `err`: `err_clr` clears it on the next edge. If a timeout and `err_clr` occur in the same cycle, set wins.
- Same cycle as timeout expiry: `acc_tlast` takes priority, so `done` pulses and `err` is not set.
- Reset (asynchronous, any state, including mid-LOAD):
  - state=IDLE, `grant`=0, `ptr`=NREQ-1 (requester 0 wins first), `wcnt`=0, `tmr`=0.
  - `pk_start`=0, `pk_write`=0, `req_ack`=0, `done`=0, `err`=0, `busy`=0, `pk_din`=0.
  - No `done` pulse is issued for an aborted burst.

## Timing
- Latency from `req` to first write: `req` sampled high at edge N puts the block in START (`pk_start`=1) during cycle N+1. LOAD begins in cycle N+2, so the first write is in cycle N+2 if `req[g]` is still high.
- Minimum burst:
  - 1 cycle IDLE, 1 START, BURST LOAD cycles, then at least 1 WAIT_DONE cycle.
  - Back-to-back grants need 1 IDLE cycle between the `done` pulse and the next START.
- `pk_start` is exactly 1 cycle wide, and exactly one pulse is issued per grant.
- `pk_write` is never high in IDLE, START or WAIT_DONE.
- Exactly BURST writes occur per grant, and `req_ack` pulses equal `pk_write` pulses.
- `grant` stays stable from START through the last WAIT_DONE cycle, and is at most one-hot.
- A timeout fires after TIMEOUT cycles in WAIT_DONE without `acc_tlast`.

## Test plan
- Single burst: reset, then `req`=0001 held with data 0x10..0x13.
  - Expect `pk_start` 1 cycle after sampling, then 4 writes 0x10,0x11,0x12,0x13 with 4 `req_ack[0]` pulses.
  - Then `acc_tlast` after 5 cycles gives `done`=0001 for 1 cycle, and `busy` falls.
- Round-robin: `req`=1111 held, with `acc_tlast` pulsed in each WAIT_DONE.
  - Expect grants in the order 0001, 0010, 0100, 1000, 0001.
  - Expect exactly 4 writes per grant, and no `req_ack` on non-granted bits.
- Stall: `req[2]` is dropped for 3 cycles after the second word.
  - Expect `pk_write`=0 for those 3 cycles, the remaining 2 words after `req[2]` reasserts, and 4 writes total.
- Timeout: TIMEOUT=8 and no `acc_tlast`.
  - Expect `err`=1 after 8 WAIT_DONE cycles, no `done`, and a return to IDLE.
  - `err_clr` pulse then clears it. Repeat with `acc_tlast` in cycle 8: `done` pulses and `err` stays 0.
- Reset mid-operation: assert `rst_n`=0 after the second write.
  - All outputs go to 0 immediately (asynchronous).
  - After release, `req`=1111 grants requester 0 first and no stale `done` appears.

Source files
------------

// File: rtl/burst_sched.sv
// ============================================================================
// burst_sched: round-robin owner of a shared packer/accelerator pair
// Revision: 1.0
// ============================================================================
`default_nettype none

module burst_sched #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST      = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            req_ack,
  output logic [NREQ-1:0]            grant,
  output logic [NREQ-1:0]            done,
  output logic                       pk_start,
  output logic                       pk_write,
  output logic [DATA_WIDTH-1:0]      pk_din,
  input  logic                       acc_tlast,
  output logic                       busy,
  output logic                       err,
  input  logic                       err_clr
);

  localparam int PW = $clog2(NREQ);
  localparam int WW = $clog2(BURST + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    LOAD      = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            err_q, err_d;

  logic [NREQ-1:0]       pick;
  logic                  found;
  logic [PW-1:0]         idx;
  logic [PW-1:0]         gidx;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  req_g;

  // Scan starts one past the last owner so every requester gets a turn.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = PW'((int'(ptr_q) + k) % NREQ);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    gidx   = '0;
    g_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        gidx   = PW'(i);
        g_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign req_g = |(req & grant_q);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    wcnt_d   = wcnt_q;
    tmr_d    = tmr_q;
    done_d   = '0;
    err_d    = err_clr ? 1'b0 : err_q;
    pk_write = 1'b0;
    req_ack  = '0;
    pk_din   = '0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = pick;
          state_d = START;
        end
      end
      START: begin
        wcnt_d  = '0;
        state_d = LOAD;
      end
      LOAD: begin
        if (req_g) begin
          pk_write = 1'b1;
          pk_din   = g_data;
          req_ack  = req & grant_q;
          wcnt_d   = wcnt_q + WW'(1);
          if (wcnt_q == WW'(BURST - 1)) begin
            state_d = WAIT_DONE;
            tmr_d   = '0;
          end
        end
      end
      WAIT_DONE: begin
        // Completion beats expiry when both land on the same cycle.
        if (acc_tlast) begin
          done_d  = grant_q;
          ptr_d   = gidx;
          grant_d = '0;
          state_d = IDLE;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          ptr_d   = gidx;
          grant_d = '0;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_RST;
      wcnt_q  <= '0;
      tmr_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      wcnt_q  <= wcnt_d;
      tmr_q   <= tmr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign grant    = grant_q;
  assign done     = done_q;
  assign err      = err_q;
  assign busy     = (state_q != IDLE);
  assign pk_start = (state_q == START);

endmodule

`default_nettype wire
